beep_tone_gen: RTL and testbench
================================

BEEP_TONE_GEN -- requirements
Module: beep_tone_gen

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter GAP_MS, default 20, silent gap after each tone, in ms.
REQ-003 SHALL derive internal constant MS_CNT = CLK_FREQ/1000, the number of clocks per ms.
REQ-004 SHALL have port sys_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port sys_rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port req_valid, input, 1 bit: a tone request is present.
REQ-007 SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-008 SHALL have port tone_div, input, 16 bits: half-period of the tone in clocks; 0 means a rest (silence).
REQ-009 SHALL have port dur_ms, input, 12 bits: tone duration in ms.
REQ-010 SHALL have port stop, input, 1 bit: synchronous abort.
REQ-011 SHALL have port beep, output, 1 bit: buzzer drive; 1 means the driver is on.
REQ-012 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse marking completion of a request.

Function
REQ-014 SHALL implement FSM states IDLE, PLAY and GAP.
REQ-015 SHALL drive req_ready=1 only in IDLE; a request is accepted on an edge where req_valid&req_ready&!stop.
REQ-016 SHALL capture tone_div and dur_ms on acceptance; input changes after acceptance have no effect.
REQ-017 On acceptance with dur_ms!=0, SHALL enter PLAY on the next cycle.
REQ-018 On acceptance with dur_ms==0, SHALL skip PLAY and GAP, stay in IDLE, and pulse done on the next cycle.
REQ-019 In PLAY with tone_div!=0, SHALL drive beep=1 in the first PLAY cycle and toggle it every tone_div clocks, giving a period of 2*tone_div clocks.
REQ-020 In PLAY with tone_div==0, SHALL hold beep=0 for the full duration.
REQ-021 SHALL remain in PLAY for exactly dur_ms*MS_CNT cycles, then enter GAP.
REQ-022 In GAP, SHALL hold beep=0 for exactly GAP_MS*MS_CNT cycles, then enter IDLE.
REQ-023 If GAP_MS==0, SHALL go directly from PLAY to IDLE.
REQ-024 SHALL pulse done high for exactly one cycle, in the first IDLE cycle after GAP; req_ready is high in that same cycle.
REQ-025 A request presented in the done cycle SHALL be accepted, allowing back-to-back tones with no extra idle cycle.
REQ-026 When stop=1 in PLAY or GAP, SHALL go to IDLE on the next cycle with beep=0 and without pulsing done.
REQ-027 When stop and req_valid are both high in IDLE, stop SHALL win and the request is not accepted.
REQ-028 SHALL size the ms sub-counter to hold MS_CNT-1, the ms counter to 12 bits, and the half-period counter to 16 bits; no counter wraps within a legal request.
REQ-029 beep SHALL be a registered output with no combinational path from any input.

Reset
REQ-030 While sys_rst=1, SHALL hold state=IDLE, beep=0, busy=0, done=0, req_ready=0, and all counters and captured registers at 0.
REQ-031 SHALL drive req_ready=1 from the first clock edge after sys_rst deasserts.
REQ-032 If sys_rst asserts mid-tone, SHALL force beep=0 immediately (asynchronously), discard the request, and produce no done.

Verification (CLK_FREQ=10_000, so MS_CNT=10; GAP_MS=2)
REQ-033 Bench SHALL cover the basic tone:
- Stimulus: tone_div=3, dur_ms=2, accepted.
- Required: beep reads 1,1,1,0,0,0 repeating for 20 cycles; then 20 cycles of 0; then done=1 for one cycle; busy high for 40 cycles.
REQ-034 Bench SHALL cover a rest: tone_div=0, dur_ms=1 -> beep=0 throughout, done 30 cycles after PLAY entry.
REQ-035 Bench SHALL cover a zero-length request: dur_ms=0 -> busy never rises, done pulses one cycle after acceptance.
REQ-036 Bench SHALL cover abort: stop asserted on PLAY cycle 7 -> IDLE and beep=0 on the next cycle, done stays 0, req_ready=1.
REQ-037 Bench SHALL cover back-to-back requests: req_valid held high with two requests -> second accepted in the done cycle, and its PLAY starts on the next cycle.
REQ-038 Bench SHALL cover reset mid-tone: sys_rst pulsed during PLAY -> beep=0 asynchronously, outputs match REQ-030, and normal operation resumes after release.

Source files
------------

// File: rtl/beep_tone_gen.sv
// beep_tone_gen: request-driven buzzer that plays a square-wave tone for dur_ms,
// then holds a silent gap, with synchronous abort and a one-cycle done pulse.
module beep_tone_gen #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int GAP_MS   = 20
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] tone_div,
  input  logic [11:0] dur_ms,
  input  logic        stop,
  output logic        beep,
  output logic        busy,
  output logic        done
);
  localparam int MS_CNT = CLK_FREQ / 1000;
  localparam int SW = MS_CNT > 1 ? $clog2(MS_CNT) : 1;
  localparam logic [SW-1:0] SUB_LAST = SW'(MS_CNT - 1);
  localparam logic [11:0] GAP_LEN = 12'(GAP_MS);
  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
  state_t state_q, state_d;
  logic [SW-1:0] sub_q, sub_d;
  logic [11:0] ms_q, ms_d;
  logic [15:0] hp_q, hp_d, div_q, div_d;
  logic beep_q, beep_d, done_q, done_d, up_q;
  logic accept, ms_tick, last_ms, hp_wrap;
  assign req_ready = up_q && state_q == IDLE;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign beep = beep_q;
  assign accept = req_valid && req_ready && !stop;
  assign ms_tick = sub_q == SUB_LAST;
  assign last_ms = ms_tick && ms_q == 12'd1;
  assign hp_wrap = hp_q == div_q - 16'd1;
  always_comb begin
    state_d = state_q;
    sub_d = '0;
    ms_d = ms_q;
    hp_d = hp_q;
    div_d = div_q;
    beep_d = beep_q;
    done_d = 1'b0;
    unique case (state_q)
      IDLE: if (accept) begin
        div_d = tone_div;
        ms_d = dur_ms;
        hp_d = '0;
        beep_d = dur_ms != '0 && tone_div != '0;
        done_d = dur_ms == '0;
        state_d = dur_ms == '0 ? IDLE : PLAY;
      end
      PLAY: begin
        sub_d = ms_tick ? '0 : sub_q + 1'b1;
        ms_d = ms_tick ? ms_q - 12'd1 : ms_q;
        hp_d = (hp_wrap || div_q == '0) ? '0 : hp_q + 16'd1;
        beep_d = div_q != '0 && (hp_wrap ? !beep_q : beep_q);
        if (last_ms) begin
          state_d = GAP_MS == 0 ? IDLE : GAP;
          ms_d = GAP_LEN;
          sub_d = '0;
          beep_d = 1'b0;
          done_d = GAP_MS == 0;
        end
      end
      GAP: begin
        sub_d = ms_tick ? '0 : sub_q + 1'b1;
        ms_d = ms_tick ? ms_q - 12'd1 : ms_q;
        if (last_ms) begin
          state_d = IDLE;
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // abort overrides everything, including a completion on the same edge
    if (stop && state_q != IDLE) begin
      state_d = IDLE;
      beep_d = 1'b0;
      done_d = 1'b0;
    end
  end
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      state_q <= IDLE;
      sub_q <= '0;
      ms_q <= '0;
      hp_q <= '0;
      div_q <= '0;
      beep_q <= 1'b0;
      done_q <= 1'b0;
      up_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sub_q <= sub_d;
      ms_q <= ms_d;
      hp_q <= hp_d;
      div_q <= div_d;
      beep_q <= beep_d;
      done_q <= done_d;
      up_q <= 1'b1;
    end
endmodule

// File: tb/tb_beep_tone_gen.sv
// tb_beep_tone_gen: directed table, corner-case sequences and a random run
// against a timeline model of the tone generator (MS_CNT=10, GAP_MS=2).
module tb_beep_tone_gen;
  logic sys_clk = 1'b0, sys_rst = 1'b1, req_valid = 1'b0, stop = 1'b0;
  logic [15:0] tone_div = '0;
  logic [11:0] dur_ms = '0;
  logic req_ready, beep, busy, done;
  int total = 0, bad = 0;
  int m_on = 0, m_k = 0, m_div = 0, m_dur = 0;
  typedef struct {
    int div; int dur; int stop_at; int cyc;
    int e_busy; int e_ones; int e_dones; int e_done_at;
  } vec_t;
  vec_t vt[7];
  beep_tone_gen #(.CLK_FREQ(10_000), .GAP_MS(2)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .req_valid(req_valid), .req_ready(req_ready),
    .tone_div(tone_div), .dur_ms(dur_ms), .stop(stop), .beep(beep), .busy(busy), .done(done)
  );
  always #5 sys_clk = ~sys_clk;
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask
  function automatic int m_len();
    return m_dur == 0 ? 0 : m_dur * 10 + 20;
  endfunction
  task automatic model_step();
    int t;
    logic b;
    t = m_len();
    b = m_on != 0 && m_k <= t;
    if (stop && b) m_on = 0;
    else if (req_valid && !b && !stop) begin
      m_on = 1; m_k = 1; m_div = int'(tone_div); m_dur = int'(dur_ms);
    end else if (m_on != 0) begin
      m_k++;
      if (m_k > t + 1) m_on = 0;
    end
  endtask
  task automatic model_check(input int c);
    int t, ph;
    logic eb, ebs, ed;
    t = m_len();
    ebs = m_on != 0 && m_k <= t;
    ed = m_on != 0 && m_k == t + 1;
    ph = m_div == 0 ? 1 : ((m_k - 1) / m_div) % 2;
    eb = m_on != 0 && m_div != 0 && m_k <= m_dur * 10 && ph == 0;
    chk($sformatf("rnd_beep@%0d", c), beep, eb);
    chk($sformatf("rnd_busy@%0d", c), busy, ebs);
    chk($sformatf("rnd_done@%0d", c), done, ed);
    chk($sformatf("rnd_ready@%0d", c), req_ready, !ebs);
  endtask
  initial begin
    logic [19:0] pat;
    int nb, no, nd, da;
    vt[0] = '{3, 2, 0, 44, 40, 11, 1, 41};
    vt[1] = '{0, 1, 0, 34, 30, 0, 1, 31};
    vt[2] = '{5, 0, 0, 4, 0, 0, 1, 1};
    vt[3] = '{1, 1, 0, 34, 30, 5, 1, 31};
    vt[4] = '{7, 1, 0, 34, 30, 7, 1, 31};
    vt[5] = '{20, 3, 0, 54, 50, 20, 1, 51};
    vt[6] = '{3, 2, 7, 12, 7, 4, 0, -1};
    pat = 20'b1110_0011_1000_1110_0011;
    step();
    step();
    chk("rst_beep", beep, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", req_ready, 0);
    sys_rst = 1'b0;
    chk("rst_ready_pre_edge", req_ready, 0);
    step();
    chk("ready_after_rst", req_ready, 1);
    chk("idle_busy", busy, 0);
    // basic tone, cycle-exact waveform
    req_valid = 1'b1; tone_div = 16'd3; dur_ms = 12'd2;
    step();
    req_valid = 1'b0; tone_div = 16'd9; dur_ms = 12'd7;
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("pat_beep%0d", i + 1), beep, pat[19-i]);
      step();
    end
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy && !beep) nb++;
      step();
    end
    chk("pat_gap_silent", nb, 20);
    chk("pat_done", done, 1);
    chk("pat_done_ready", req_ready, 1);
    step();
    chk("pat_done_once", done, 0);
    // table of whole requests
    for (int r = 0; r < 7; r++) begin
      req_valid = 1'b1; tone_div = 16'(vt[r].div); dur_ms = 12'(vt[r].dur);
      step();
      req_valid = 1'b0; tone_div = 16'($urandom); dur_ms = 12'($urandom);
      nb = 0; no = 0; nd = 0; da = -1;
      for (int k = 1; k <= vt[r].cyc; k++) begin
        if (busy) nb++;
        if (beep) no++;
        if (done) begin
          nd++;
          if (da < 0) da = k;
        end
        if (k == vt[r].stop_at) stop = 1'b1;
        step();
        stop = 1'b0;
      end
      chk($sformatf("row%0d_busy", r), nb, vt[r].e_busy);
      chk($sformatf("row%0d_ones", r), no, vt[r].e_ones);
      chk($sformatf("row%0d_dones", r), nd, vt[r].e_dones);
      chk($sformatf("row%0d_done_at", r), da, vt[r].e_done_at);
      chk($sformatf("row%0d_ready", r), req_ready, 1);
    end
    // stop wins over a request in IDLE
    req_valid = 1'b1; stop = 1'b1; tone_div = 16'd2; dur_ms = 12'd1;
    step();
    req_valid = 1'b0; stop = 1'b0;
    chk("stop_wins_busy", busy, 0);
    chk("stop_wins_done", done, 0);
    // back-to-back with req_valid held high
    req_valid = 1'b1; tone_div = 16'd2; dur_ms = 12'd1;
    step();
    tone_div = 16'd4; dur_ms = 12'd2;
    nb = 0;
    for (int i = 1; i <= 30; i++) begin
      if (busy) nb++;
      step();
    end
    chk("b2b_first_busy", nb, 30);
    chk("b2b_done", done, 1);
    chk("b2b_done_ready", req_ready, 1);
    step();
    req_valid = 1'b0;
    chk("b2b_second_busy", busy, 1);
    chk("b2b_second_beep", beep, 1);
    step(); step(); step();
    chk("b2b_second_beep4", beep, 1);
    step();
    chk("b2b_second_beep5", beep, 0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("b2b_abort_busy", busy, 0);
    chk("b2b_abort_done", done, 0);
    // reset mid-tone
    req_valid = 1'b1; tone_div = 16'd5; dur_ms = 12'd3;
    step();
    req_valid = 1'b0;
    step(); step();
    chk("mid_pre_beep", beep, 1);
    #2 sys_rst = 1'b1;
    #1;
    chk("mid_rst_beep", beep, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_ready", req_ready, 0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    step();
    chk("mid_rel_ready", req_ready, 1);
    chk("mid_rel_done", done, 0);
    req_valid = 1'b1; tone_div = 16'd1; dur_ms = 12'd0;
    step();
    req_valid = 1'b0;
    chk("mid_zero_done", done, 1);
    chk("mid_zero_busy", busy, 0);
    step();
    chk("mid_zero_done_once", done, 0);
    // random traffic against the timeline model
    m_on = 0;
    for (int c = 0; c < 3000; c++) begin
      req_valid = ($urandom % 3) == 0;
      tone_div = 16'($urandom_range(0, 4));
      dur_ms = 12'($urandom_range(0, 2));
      stop = ($urandom % 50) == 0;
      model_step();
      step();
      model_check(c);
    end
    req_valid = 1'b0; stop = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
